// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared state encoding and instruction field bounds for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam int unsigned OP_MSB      = 31;
    localparam int unsigned OP_LSB      = 26;
    localparam int unsigned FUNCT_MSB   = 5;
    localparam int unsigned FUNCT_LSB   = 0;
    localparam int unsigned IMM_MSB     = 15;
    localparam int unsigned IMM_LSB     = 0;
    localparam int unsigned JTARGET_MSB = 25;
    localparam int unsigned JTARGET_LSB = 0;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

`default_nettype wire

// File: rtl/next_pc_calc.sv
// ============================================================================
// Module   : next_pc_calc
// Purpose  : Combinational next-PC selection: jump, taken branch, or sequential.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] jump_target;
    logic        unused_op_bits;

    // The opcode field plays no part in target arithmetic.
    assign unused_op_bits = ^instr[OP_MSB:OP_LSB];

    always_comb begin
        pc_plus4    = pc + PC_STEP;
        branch_off  = {{14{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};
        jump_target = {pc_plus4[31:28], instr[JTARGET_MSB:JTARGET_LSB], 2'b00};
        next_pc     = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : MIPS fetch stage: PC register, imem req/ack handshake, next-PC on retire.
//            Optional perf counters enabled by macro FETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        retire,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] cnt_retired,
    output logic [31:0] cnt_wait
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  next_pc;

    next_pc_calc u_next_pc_calc (
        .pc      (pc_q),
        .instr   (instr_q),
        .jump    (jump),
        .branch  (branch),
        .zero    (zero),
        .next_pc (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    state_d = HOLD;
                    instr_d = imem_rdata;
                end
            end
            HOLD: begin
                if (retire) begin
                    state_d = REQ;
                    pc_d    = next_pc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Handshake outputs come straight off the state register, so no comb path from ack.
    assign imem_req    = (state_q == REQ);
    assign instr_valid = (state_q == HOLD);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign op          = instr_q[OP_MSB:OP_LSB];
    assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cnt_retired_q, cnt_retired_d;
    logic [31:0] cnt_wait_q, cnt_wait_d;

    always_comb begin
        cnt_retired_d = cnt_retired_q;
        cnt_wait_d    = cnt_wait_q;
        if ((state_q == HOLD) && retire && (cnt_retired_q != 32'hFFFF_FFFF)) begin
            cnt_retired_d = cnt_retired_q + 32'd1;
        end
        if ((state_q == REQ) && !imem_ack && (cnt_wait_q != 32'hFFFF_FFFF)) begin
            cnt_wait_d = cnt_wait_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_retired_q <= 32'h0;
            cnt_wait_q    <= 32'h0;
        end else begin
            cnt_retired_q <= cnt_retired_d;
            cnt_wait_q    <= cnt_wait_d;
        end
    end

    assign cnt_retired = cnt_retired_q;
    assign cnt_wait    = cnt_wait_q;
`else
    assign cnt_retired = 32'h0;
    assign cnt_wait    = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit (directed table, random vs model, reset cases).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic        retire;
    logic        jump;
    logic        branch;
    logic        zero;
    logic [31:0] cnt_retired;
    logic [31:0] cnt_wait;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .op          (op),
        .funct       (funct),
        .instr_valid (instr_valid),
        .pc          (pc),
        .retire      (retire),
        .jump        (jump),
        .branch      (branch),
        .zero        (zero),
        .cnt_retired (cnt_retired),
        .cnt_wait    (cnt_wait)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: what the fetch stage is doing, not how the RTL encodes it.
    bit          m_started;
    bit          m_have_instr;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    int unsigned m_ret;
    int unsigned m_wait;

    function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] iw,
                                             input bit j, input bit b, input bit z);
        logic [31:0] p4;
        int          off;
        p4 = cur_pc + 32'd4;
        if (j) return (p4 & 32'hF000_0000) | ({6'b0, iw[25:0]} << 2);
        if (b && z) begin
            off = int'($signed(iw[15:0])) * 4;
            return p4 + 32'(off);
        end
        return p4;
    endfunction

    task automatic model_reset();
        m_started    = 0;
        m_have_instr = 0;
        m_pc         = RST_PC;
        m_instr      = 32'h0;
        m_ret        = 0;
        m_wait       = 0;
    endtask

    // Applies inputs for the coming edge, advances the model, and returns #1 after the edge.
    task automatic cycle(input bit a, input logic [31:0] rd, input bit r, input bit j,
                         input bit b, input bit z);
        imem_ack   = a;
        imem_rdata = rd;
        retire     = r;
        jump       = j;
        branch     = b;
        zero       = z;
        if (!m_started) begin
            m_started = 1;
        end else if (m_have_instr) begin
            if (r) begin
                m_pc         = ref_next(m_pc, m_instr, j, b, z);
                m_have_instr = 0;
                m_ret++;
            end
        end else if (a) begin
            m_instr      = rd;
            m_have_instr = 1;
        end else begin
            m_wait++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] e_ret, e_wait;
`ifdef FETCH_PERF_CNT_EN
        e_ret  = m_ret;
        e_wait = m_wait;
`else
        e_ret  = 32'h0;
        e_wait = 32'h0;
`endif
        check32({tag, ".req"},   32'(imem_req),    32'(m_started && !m_have_instr));
        check32({tag, ".valid"}, 32'(instr_valid), 32'(m_have_instr));
        check32({tag, ".pc"},    pc,               m_pc);
        check32({tag, ".addr"},  imem_addr,        m_pc);
        check32({tag, ".instr"}, instr,            m_instr);
        check32({tag, ".op"},    32'(op),          32'(m_instr[31:26]));
        check32({tag, ".funct"}, 32'(funct),       32'(m_instr[5:0]));
        check32({tag, ".cret"},  cnt_retired,      e_ret);
        check32({tag, ".cwait"}, cnt_wait,         e_wait);
    endtask

    typedef struct {
        bit          ack;
        logic [31:0] rdata;
        bit          ret;
        bit          j;
        bit          b;
        bit          z;
        bit          e_req;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[22];

    initial begin
        //            ack  rdata          ret j  b  z   req val pc             instr
        vecs[0]  = '{0, 32'h0,         0, 0, 0, 0,  1, 0, 32'h0000_3000, 32'h0};
        vecs[1]  = '{1, 32'h0000_0020, 0, 0, 0, 0,  0, 1, 32'h0000_3000, 32'h0000_0020};
        vecs[2]  = '{0, 32'h0,         1, 0, 0, 0,  1, 0, 32'h0000_3004, 32'h0000_0020};
        vecs[3]  = '{1, 32'h1000_FFFF, 0, 0, 0, 0,  0, 1, 32'h0000_3004, 32'h1000_FFFF};
        vecs[4]  = '{0, 32'h0,         1, 0, 1, 1,  1, 0, 32'h0000_3004, 32'h1000_FFFF};
        vecs[5]  = '{1, 32'h1000_FFFF, 0, 0, 0, 0,  0, 1, 32'h0000_3004, 32'h1000_FFFF};
        vecs[6]  = '{0, 32'h0,         1, 0, 1, 0,  1, 0, 32'h0000_3008, 32'h1000_FFFF};
        vecs[7]  = '{1, 32'h0800_0100, 0, 0, 0, 0,  0, 1, 32'h0000_3008, 32'h0800_0100};
        vecs[8]  = '{0, 32'h0,         1, 1, 0, 0,  1, 0, 32'h0000_0400, 32'h0800_0100};
        vecs[9]  = '{1, 32'h0800_0100, 0, 0, 0, 0,  0, 1, 32'h0000_0400, 32'h0800_0100};
        vecs[10] = '{0, 32'h0,         1, 1, 1, 1,  1, 0, 32'h0000_0400, 32'h0800_0100};
        vecs[11] = '{1, 32'h0800_0000, 0, 0, 0, 0,  0, 1, 32'h0000_0400, 32'h0800_0000};
        vecs[12] = '{0, 32'h0,         1, 1, 0, 0,  1, 0, 32'h0000_0000, 32'h0800_0000};
        vecs[13] = '{1, 32'h1000_FFFE, 0, 0, 0, 0,  0, 1, 32'h0000_0000, 32'h1000_FFFE};
        vecs[14] = '{0, 32'h0,         1, 0, 1, 1,  1, 0, 32'hFFFF_FFFC, 32'h1000_FFFE};
        vecs[15] = '{1, 32'h0000_0000, 0, 0, 0, 0,  0, 1, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[16] = '{0, 32'h0,         1, 0, 0, 0,  1, 0, 32'h0000_0000, 32'h0000_0000};
        vecs[17] = '{0, 32'h0,         0, 0, 0, 0,  1, 0, 32'h0000_0000, 32'h0000_0000};
        vecs[18] = '{0, 32'h0,         1, 1, 0, 0,  1, 0, 32'h0000_0000, 32'h0000_0000};
        vecs[19] = '{0, 32'h0,         0, 0, 0, 0,  1, 0, 32'h0000_0000, 32'h0000_0000};
        vecs[20] = '{1, 32'h0000_0021, 0, 0, 0, 0,  0, 1, 32'h0000_0000, 32'h0000_0021};
        vecs[21] = '{1, 32'hDEAD_BEEF, 0, 0, 0, 0,  0, 1, 32'h0000_0000, 32'h0000_0021};

        rst_n = 1'b0;
        imem_ack = 0; imem_rdata = 32'h0; retire = 0; jump = 0; branch = 0; zero = 0;
        model_reset();
        #12;
        check32("rst.req",   32'(imem_req),    32'h0);
        check32("rst.valid", 32'(instr_valid), 32'h0);
        check32("rst.pc",    pc,               RST_PC);
        check32("rst.instr", instr,            32'h0);
        check32("rst.op",    32'(op),          32'h0);
        check32("rst.funct", 32'(funct),       32'h0);
        check32("rst.cret",  cnt_retired,      32'h0);
        check32("rst.cwait", cnt_wait,         32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            cycle(vecs[i].ack, vecs[i].rdata, vecs[i].ret, vecs[i].j, vecs[i].b, vecs[i].z);
            check32($sformatf("vec%0d.req", i),   32'(imem_req),    32'(vecs[i].e_req));
            check32($sformatf("vec%0d.valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            check32($sformatf("vec%0d.addr", i),  imem_addr,        vecs[i].e_pc);
            check32($sformatf("vec%0d.pc", i),    pc,               vecs[i].e_pc);
            check32($sformatf("vec%0d.instr", i), instr,            vecs[i].e_instr);
            check32($sformatf("vec%0d.funct", i), 32'(funct),       32'(vecs[i].e_instr[5:0]));
        end
`ifdef FETCH_PERF_CNT_EN
        check32("tbl.cret",  cnt_retired, 32'd8);
        check32("tbl.cwait", cnt_wait,    32'd3);
`else
        check32("tbl.cret",  cnt_retired, 32'd0);
        check32("tbl.cwait", cnt_wait,    32'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            check_model("rnd");
        end

        // Force REQ: from HOLD a retire moves there, from REQ an un-acked cycle stays.
        cycle(0, 32'h0, 1, 0, 0, 0);
        check32("pre_rst.req", 32'(imem_req), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check32("async.req",   32'(imem_req),    32'h0);
        check32("async.valid", 32'(instr_valid), 32'h0);
        check32("async.pc",    pc,               RST_PC);
        check32("async.instr", instr,            32'h0);
        check32("async.cret",  cnt_retired,      32'h0);
        check32("async.cwait", cnt_wait,         32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 32'hBAD0_BAD0, 0, 0, 0, 0);
        check_model("late_ack");
        check32("late_ack.addr", imem_addr, RST_PC);
        cycle(0, 32'h0, 0, 0, 0, 0);
        check_model("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
